// File: rtl/rans_ctrl.sv
// rANS encoder controller: streams the frequency table into the encoder, feeds symbols under
// output-FIFO credit, and buffers encoder bytes. Optional table-sum check: RANS_CTRL_SUM_CHECK_EN.
module rans_ctrl #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int ENC_LAT      = 2,
  parameter int OUT_DEPTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    tbl_valid_i,
  output logic                    tbl_ready_o,
  input  logic [RESOLUTION-1:0]   tbl_freq_i,
  input  logic                    sym_valid_i,
  output logic                    sym_ready_o,
  input  logic [SYMBOL_WIDTH-1:0] sym_i,
  input  logic                    sym_last_i,
  output logic                    enc_en_o,
  output logic                    enc_freq_wr_o,
  output logic [RESOLUTION-1:0]   enc_freq_o,
  output logic [RESOLUTION-1:0]   enc_cum_freq_o,
  output logic [SYMBOL_WIDTH-1:0] enc_symb_o,
  input  logic                    enc_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] enc_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SYMBOL_WIDTH-1:0] out_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(ENC_LAT + 2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] CREDIT_C = CW'(ENC_LAT + 1);
  localparam logic [DW-1:0] DRAIN_C  = DW'(ENC_LAT + 1);
`ifdef RANS_CTRL_SUM_CHECK_EN
  localparam logic [RESOLUTION:0] FULL_SUM = (RESOLUTION+1)'(1) << RESOLUTION;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [SYMBOL_WIDTH-1:0] idx;
  logic [RESOLUTION:0]     sum, sum_nxt;
  logic [DW-1:0]           drain_cnt;
  logic [SYMBOL_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic tbl_beat, sym_acc, last_idx, drain_end, push, pop, full;

  // Combinational outputs are gated by rst_i so they read 0 for the whole reset window.
  assign tbl_ready_o = !rst_i && (state == LOAD);
  assign sym_ready_o = !rst_i && (state == RUN) && ((DEPTH_C - count) > CREDIT_C);
  assign busy_o      = !rst_i && (state != IDLE);
  assign out_valid_o = !rst_i && (count != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

  assign tbl_beat  = tbl_valid_i && tbl_ready_o;
  assign sym_acc   = sym_valid_i && sym_ready_o;
  assign last_idx  = (idx == '1);
  assign drain_end = (state == DRAIN) && (drain_cnt <= DW'(1));
  assign sum_nxt   = sum + {1'b0, tbl_freq_i};
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid_o && out_ready_i;
  assign push      = enc_valid_i && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    if (tbl_beat && last_idx) state_nxt = RUN;
      RUN:     if (sym_acc && sym_last_i) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= enc_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx            <= '0;
      sum            <= '0;
      drain_cnt      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      enc_en_o       <= 1'b0;
      enc_freq_wr_o  <= 1'b0;
      enc_freq_o     <= '0;
      enc_cum_freq_o <= '0;
      enc_symb_o     <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      enc_en_o      <= sym_acc;
      enc_freq_wr_o <= tbl_beat;
      done_o        <= drain_end;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (enc_valid_i && !push) err_o <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          idx   <= '0;
          sum   <= '0;
          err_o <= 1'b0;
        end
        LOAD: if (tbl_beat) begin
          enc_symb_o     <= idx;
          enc_freq_o     <= tbl_freq_i;
          enc_cum_freq_o <= sum[RESOLUTION-1:0];
          sum            <= sum_nxt;
          if (!last_idx) idx <= idx + SYMBOL_WIDTH'(1);
`ifdef RANS_CTRL_SUM_CHECK_EN
          if (last_idx && (sum_nxt != FULL_SUM)) err_o <= 1'b1;
`endif
        end
        RUN: if (sym_acc) begin
          enc_symb_o <= sym_i;
          if (sym_last_i) drain_cnt <= DRAIN_C;
        end
        DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rans_ctrl.sv
// Self-checking bench for rans_ctrl: table-driven load cases, directed FIFO/reset sequences and
// randomized messages checked against a queue-based reference model.
module tb_rans_ctrl;
  localparam int RES = 10, SW = 8, LAT = 2, DEPTH = 8, NSYM = 256;
`ifdef RANS_CTRL_SUM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i, start_i, tbl_valid_i, tbl_ready_o, sym_valid_i, sym_ready_o, sym_last_i;
  logic enc_en_o, enc_freq_wr_o, enc_valid_i, out_valid_o, out_ready_i, busy_o, done_o, err_o;
  logic [RES-1:0] tbl_freq_i, enc_freq_o, enc_cum_freq_o;
  logic [SW-1:0]  sym_i, enc_symb_o, enc_data_i, out_data_o;

  always #5 clk_i = ~clk_i;

  rans_ctrl #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW), .ENC_LAT(LAT), .OUT_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .tbl_valid_i(tbl_valid_i), .tbl_ready_o(tbl_ready_o), .tbl_freq_i(tbl_freq_i),
    .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_i(sym_i), .sym_last_i(sym_last_i),
    .enc_en_o(enc_en_o), .enc_freq_wr_o(enc_freq_wr_o), .enc_freq_o(enc_freq_o),
    .enc_cum_freq_o(enc_cum_freq_o), .enc_symb_o(enc_symb_o),
    .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain; the output FIFO is a plain queue.
  int            m_phase = 0;
  int            m_left  = 0;
  bit            m_err   = 1'b0;
  logic [SW-1:0] m_q[$];
  logic [SW:0]   dl[$];

  typedef struct { int f0; int fr; bit exp_err; } lcase_t;
  lcase_t cases[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tbl_ready"}, 32'(tbl_ready_o), 0);
    check({tag, "_sym_ready"}, 32'(sym_ready_o), 0);
    check({tag, "_enc_en"},    32'(enc_en_o), 0);
    check({tag, "_freq_wr"},   32'(enc_freq_wr_o), 0);
    check({tag, "_freq"},      32'(enc_freq_o), 0);
    check({tag, "_cum"},       32'(enc_cum_freq_o), 0);
    check({tag, "_symb"},      32'(enc_symb_o), 0);
    check({tag, "_out_valid"}, 32'(out_valid_o), 0);
    check({tag, "_out_data"},  32'(out_data_o), 0);
    check({tag, "_busy"},      32'(busy_o), 0);
    check({tag, "_done"},      32'(done_o), 0);
    check({tag, "_err"},       32'(err_o), 0);
  endtask

  // One clock outside LOAD: apply inputs, advance the model, compare every observable output.
  task automatic cyc(input bit sv, input logic [SW-1:0] s, input bit sl, input bit ordy,
                     input bit ev, input logic [SW-1:0] ed, output bit acc);
    bit pop, done_exp;
    acc = sv && (m_phase == 1) && (DEPTH - m_q.size() > LAT + 1);
    pop = ordy && (m_q.size() > 0);
    sym_valid_i = sv; sym_i = s; sym_last_i = sl; out_ready_i = ordy;
    enc_valid_i = ev; enc_data_i = ed;
    tbl_valid_i = 1'($urandom_range(0, 1)); tbl_freq_i = RES'($urandom);
    start_i = (m_phase != 0) && ($urandom_range(0, 1) == 1);
    @(posedge clk_i); #1;
    done_exp = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(ed);
      else m_err = 1'b1;
    end
    if (m_phase == 1 && acc && sl) begin
      m_phase = 2; m_left = LAT + 1;
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) begin m_phase = 0; done_exp = 1'b1; end
    end
    check("enc_en", 32'(enc_en_o), 32'(acc));
    if (acc) check("enc_symb", 32'(enc_symb_o), 32'(s));
    check("freq_wr_idle", 32'(enc_freq_wr_o), 0);
    check("tbl_ready_off", 32'(tbl_ready_o), 0);
    check("done", 32'(done_o), 32'(done_exp));
    check("busy", 32'(busy_o), 32'(m_phase != 0));
    check("sym_ready", 32'(sym_ready_o), 32'((m_phase == 1) && (DEPTH - m_q.size() > LAT + 1)));
    check("out_valid", 32'(out_valid_o), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", 32'(out_data_o), 32'(m_q[0]));
    check("err", 32'(err_o), 32'(m_err));
    start_i = 1'b0;
  endtask

  task automatic do_start();
    tbl_valid_i = 1'b0; sym_valid_i = 1'b0; enc_valid_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("start_busy", 32'(busy_o), 1);
    check("start_tbl_ready", 32'(tbl_ready_o), 1);
    check("start_err_clr", 32'(err_o), 0);
  endtask

  // Streams up to max_beats table entries with random valid gaps; counts beats that went wrong.
  task automatic load_table(input int f0, input int fr, input int max_beats,
                            output int bad, output int writes);
    int idx, sum, freq;
    bit beat;
    idx = 0; sum = 0; bad = 0; writes = 0;
    sym_valid_i = 1'b0; enc_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int c = 0; c < 4000 && idx < max_beats; c++) begin
      beat = ($urandom_range(0, 3) != 0);
      freq = (idx == 0) ? f0 : fr;
      tbl_valid_i = beat; tbl_freq_i = RES'(freq);
      if (tbl_ready_o !== 1'b1 || sym_ready_o !== 1'b0) bad++;
      @(posedge clk_i); #1;
      if (enc_freq_wr_o !== beat || enc_en_o !== 1'b0) bad++;
      if (beat) begin
        writes++;
        if (enc_symb_o !== SW'(idx) || enc_freq_o !== RES'(freq) || enc_cum_freq_o !== RES'(sum)) bad++;
        sum += freq; idx++;
      end
    end
    tbl_valid_i = 1'b0;
  endtask

  task automatic load_case(input int f0, input int fr, input bit exp_err, input string tag);
    int bad, writes;
    do_start();
    load_table(f0, fr, NSYM, bad, writes);
    check({tag, "_writes"}, 32'(writes), NSYM);
    check({tag, "_bad_beats"}, 32'(bad), 0);
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
    check({tag, "_run_ready"}, 32'(sym_ready_o), 1);
    check({tag, "_tbl_closed"}, 32'(tbl_ready_o), 0);
    m_phase = 1; m_err = exp_err; m_q.delete();
  endtask

  // Random message of n symbols with a compliant encoder (one byte per symbol, fixed delay).
  task automatic run_msg(input int n);
    int sent;
    bit acc;
    logic [SW:0] e;
    logic [SW-1:0] s;
    sent = 0;
    dl.delete();
    for (int i = 0; i < LAT; i++) dl.push_back('0);
    for (int c = 0; c < 3000 && m_phase != 0; c++) begin
      s = SW'($urandom);
      e = dl.pop_back();
      cyc(($urandom_range(0, 3) != 0), s, (sent == n - 1), 1'($urandom_range(0, 1)), e[SW], e[SW-1:0], acc);
      dl.push_front({acc, s ^ 8'hA5});
      if (acc) sent++;
    end
    for (int c = 0; c < LAT + DEPTH + 4; c++) begin
      e = dl.pop_back();
      cyc(1'b0, '0, 1'b0, 1'b1, e[SW], e[SW-1:0], acc);
      dl.push_front('0);
    end
    check("msg_idle", 32'(busy_o), 0);
    check("msg_drained", 32'(out_valid_o), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int bad, writes;
    cases[0] = '{f0: 4,    fr: 4,    exp_err: 1'b0};
    cases[1] = '{f0: 5,    fr: 4,    exp_err: CHK};
    cases[2] = '{f0: 0,    fr: 4,    exp_err: CHK};
    cases[3] = '{f0: 259,  fr: 3,    exp_err: 1'b0};
    cases[4] = '{f0: 1023, fr: 1023, exp_err: CHK};

    rst_i = 1'b1; start_i = 1'b0; tbl_valid_i = 1'b0; tbl_freq_i = '0; sym_valid_i = 1'b0;
    sym_i = '0; sym_last_i = 1'b0; enc_valid_i = 1'b0; enc_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("rst");
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load_case(cases[i].f0, cases[i].fr, cases[i].exp_err, $sformatf("load%0d", i));
      run_msg((i == 0) ? 3 : int'($urandom_range(5, 30)));
    end

    // Fill the FIFO with output stalled; credit must close at 5 occupied entries.
    load_case(4, 4, 1'b0, "fifo");
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, SW'(8'h10 + i), acc);
      if (i == 3) check("credit_occ4", 32'(sym_ready_o), 1);
      if (i == 4) check("credit_occ5", 32'(sym_ready_o), 0);
    end
    check("full_no_err", 32'(err_o), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, SW'(8'h20 + i), acc);
    check("full_pushpop_valid", 32'(out_valid_o), 1);
    check("full_pushpop_err", 32'(err_o), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'hEE, acc);
    check("overflow_err", 32'(err_o), 1);

    // Reset mid-RUN with a full FIFO: contents discarded, no done.
    rst_i = 1'b1; enc_valid_i = 1'b1; sym_valid_i = 1'b1;
    @(posedge clk_i); #1;
    check_all_zero("rst_run");
    rst_i = 1'b0; enc_valid_i = 1'b0; sym_valid_i = 1'b0;
    m_phase = 0; m_err = 1'b0; m_q.delete();
    @(posedge clk_i); #1;
    check("rst_run_fifo_empty", 32'(out_valid_o), 0);
    check("rst_run_no_done", 32'(done_o), 0);

    // Reset at load index 100, then a fresh load must restart from index 0.
    do_start();
    load_table(4, 4, 100, bad, writes);
    check("partial_writes", 32'(writes), 100);
    check("partial_bad_beats", 32'(bad), 0);
    rst_i = 1'b1; tbl_valid_i = 1'b1;
    @(posedge clk_i); #1;
    check_all_zero("rst_load");
    rst_i = 1'b0; tbl_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("rst_load_no_done", 32'(done_o), 0);
      check("rst_load_idle", 32'(busy_o), 0);
    end
    load_case(4, 4, 1'b0, "reload");
    run_msg(int'($urandom_range(3, 12)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rans_ctrl.md
RANS_CTRL -- requirements
Module: rans_ctrl

Interface
REQ-001 Parameters SHALL be: RESOLUTION, default 10, probability resolution bits; SYMBOL_WIDTH, default 8, symbol bits; ENC_LAT, default 2, encoder symbol-to-output latency in cycles; OUT_DEPTH, default 8, output FIFO entries, power of two, at least ENC_LAT+2.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  begin table load; sampled only in IDLE
- tbl_valid_i / tbl_ready_o  in / out  1 / 1  table handshake
- tbl_freq_i  in  RESOLUTION  frequency of the next symbol, in order 0..2^SYMBOL_WIDTH-1
- sym_valid_i / sym_ready_o  in / out  1 / 1  symbol handshake
- sym_i  in  SYMBOL_WIDTH  symbol to encode
- sym_last_i  in  1  final symbol of the message
- enc_en_o  out  1  encoder enable
- enc_freq_wr_o  out  1  encoder table write strobe
- enc_freq_o  out  RESOLUTION  frequency to the encoder
- enc_cum_freq_o  out  RESOLUTION  cumulative frequency to the encoder
- enc_symb_o  out  SYMBOL_WIDTH  symbol, or table index during load
- enc_valid_i  in  1  encoder output valid
- enc_data_i  in  SYMBOL_WIDTH  encoder output byte
- out_valid_o / out_ready_i  out / in  1 / 1  output stream handshake
- out_data_o  out  SYMBOL_WIDTH  output byte
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse at end of drain
- err_o  out  1  sticky table-sum error

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, RUN and DRAIN.
REQ-005 IDLE SHALL go to LOAD when start_i=1; it clears the index counter and the running sum.
REQ-006 In LOAD, tbl_ready_o SHALL be 1; each tbl_valid_i&&tbl_ready_o beat SHALL register, on the next cycle:
- enc_freq_wr_o=1
- enc_symb_o=index
- enc_freq_o=tbl_freq_i
- enc_cum_freq_o=running sum before this beat
REQ-007 The running sum SHALL be RESOLUTION+1 bits wide; enc_cum_freq_o SHALL be its low RESOLUTION bits.
REQ-008 After the beat at index 2^SYMBOL_WIDTH-1, the FSM SHALL go to RUN; the index SHALL not wrap.
REQ-009 In RUN, sym_ready_o SHALL equal (FIFO free entries > ENC_LAT+1).
REQ-010 Each accepted symbol SHALL register, on the next cycle, enc_en_o=1 and enc_symb_o=sym_i; with no accept, enc_en_o SHALL be 0.
REQ-011 Accepting a symbol with sym_last_i=1 SHALL move the FSM to DRAIN and load a drain counter with ENC_LAT+1.
REQ-012 DRAIN SHALL decrement the drain counter each cycle and, when it reaches 0, pulse done_o for one cycle and return to IDLE.
REQ-013 Every enc_valid_i=1 cycle SHALL push enc_data_i into the output FIFO, in any state.
REQ-014 A push when the FIFO is full SHALL drop the byte and set err_o; the credit rule in REQ-009 makes this unreachable with a compliant encoder.
REQ-015 out_valid_o SHALL be 1 whenever the FIFO is non-empty; out_data_o SHALL be the head entry; pop on out_valid_o&&out_ready_i.
REQ-016 A simultaneous push and pop SHALL leave the occupancy unchanged; FIFO pointers SHALL wrap modulo OUT_DEPTH.
REQ-017 tbl_ready_o SHALL be 0 outside LOAD; sym_ready_o SHALL be 0 outside RUN.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 busy_o SHALL be 1 in LOAD, RUN and DRAIN.
REQ-020 err_o SHALL clear only on rst_i or on the IDLE->LOAD transition.

Reset
REQ-021 When rst_i=1, the state SHALL become IDLE, and the counters, running sum and FIFO pointers SHALL be cleared.
REQ-022 When rst_i=1, all outputs SHALL be 0, including enc_en_o, enc_freq_wr_o, out_valid_o, done_o and err_o.
REQ-023 Reset mid-LOAD or mid-RUN SHALL abandon the operation without emitting done_o; FIFO contents SHALL be discarded.

Configuration
REQ-024 With macro RANS_CTRL_SUM_CHECK_EN defined, on the LOAD->RUN transition err_o SHALL be set if the final running sum is not 2^RESOLUTION.
REQ-025 Without RANS_CTRL_SUM_CHECK_EN, the sum check SHALL be absent; err_o SHALL report only FIFO overflow.

Verification
REQ-026 The bench SHALL cover these directed scenarios (defaults unless stated):
- Load 256 frequencies of 4 each -> 256 writes with cum_freq 0,4,...,1020; then RUN; err_o=0.
- Load with frequency[0]=5 and the rest 4, macro defined -> err_o=1 at RUN entry; macro undefined -> err_o=0.
- RUN with out_ready_i=0 and the encoder pulsing enc_valid_i every cycle -> sym_ready_o falls at 5 occupied entries; no overflow.
- Send 3 symbols, the last with sym_last_i=1 -> done_o pulses exactly 3 cycles after the last accept; busy_o falls the same cycle.
- rst_i asserted at load index 100 -> IDLE, all outputs 0, no done_o; a fresh start_i reloads from index 0.
- Simultaneous push and pop with the FIFO full -> occupancy stays OUT_DEPTH; err_o=0.
